pc_seq: RTL

PC_SEQ -- requirements
Module: pc_seq

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/pc_seq_if.sv | 21 ++
 rtl/redirect_buf.sv | 66 ++++++
 rtl/pc_seq.sv | 103 ++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the PC sequencer: default reset/exception PCs,
// fetch FSM state encoding, redirect-source encoding and PC alignment helper.
package cpu_pkg;

    localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
    localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_4180;

    typedef enum logic {
        FETCH = 1'b0,
        WAIT  = 1'b1
    } state_e;

    // Where the next PC comes from when a fetch is accepted.
    typedef enum logic [2:0] {
        SRC_NONE = 3'd0,
        SRC_BR   = 3'd1,
        SRC_JUMP = 3'd2,
        SRC_JR   = 3'd3,
        SRC_BUF  = 3'd4
    } src_e;

    // Instruction addresses are word aligned; low bits of any target are dropped.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_seq_if.sv
// Instruction-fetch bus between the PC sequencer (master) and instruction memory (slave).
interface pc_seq_if;
    logic        imem_req_o;
    logic        imem_ready_i;
    logic [31:0] pc_o;
    logic [31:0] pc4_o;

    modport master (
        output imem_req_o,
        output pc_o,
        output pc4_o,
        input  imem_ready_i
    );

    modport slave (
        input  imem_req_o,
        input  pc_o,
        input  pc4_o,
        output imem_ready_i
    );
endinterface

// File: rtl/redirect_buf.sv
// One-entry redirect buffer with the jr > jump > branch > buffered priority mux.
// A redirect that cannot be applied (fetch not accepted) is parked here; a
// newer redirect overwrites it, and any accepted fetch or flush empties it.
module redirect_buf
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        br_taken_i,
    input  logic [31:0] br_target_i,
    input  logic        jump_i,
    input  logic [31:0] jump_target_i,
    input  logic        jr_i,
    input  logic [31:0] jr_target_i,
    input  logic        accept_i,
    input  logic        flush_i,
    output src_e        redirect_src_o,
    output logic [31:0] redirect_target_o,
    output logic        pending_o
);

    logic        buf_valid_reg;
    logic [31:0] buf_target_reg;
    logic        new_valid;
    logic [31:0] new_target;

    // Priority selection among live redirects, falling back to the buffered one.
    always_comb begin
        new_valid         = 1'b0;
        new_target        = 32'h0;
        redirect_src_o    = SRC_NONE;
        redirect_target_o = 32'h0;
        if (jr_i) begin
            new_valid      = 1'b1;
            new_target     = align_pc(jr_target_i);
            redirect_src_o = SRC_JR;
        end else if (jump_i) begin
            new_valid      = 1'b1;
            new_target     = align_pc(jump_target_i);
            redirect_src_o = SRC_JUMP;
        end else if (br_taken_i) begin
            new_valid      = 1'b1;
            new_target     = align_pc(br_target_i);
            redirect_src_o = SRC_BR;
        end else if (buf_valid_reg) begin
            redirect_src_o = SRC_BUF;
        end
        redirect_target_o = new_valid ? new_target : buf_target_reg;
    end

    // Capture an unapplied redirect; clear on acceptance (a live redirect wins and the old entry is dropped).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_valid_reg  <= 1'b0;
            buf_target_reg <= 32'h0;
        end else if (flush_i || accept_i) begin
            buf_valid_reg  <= 1'b0;
        end else if (new_valid) begin
            buf_valid_reg  <= 1'b1;
            buf_target_reg <= new_target;
        end
    end

    assign pending_o = buf_valid_reg;

endmodule

// File: rtl/pc_seq.sv
// PC sequencer for the IF stage: FETCH/WAIT handshake with instruction memory,
// next-PC selection (redirects or pc+4), stall hold and redirect buffering.
// Optional feature macro: PC_EXC_EN adds exc_i, a top-priority jump to EXC_VECTOR.
module pc_seq
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_target_i,
    input  logic        jump_i,
    input  logic [31:0] jump_target_i,
    input  logic        jr_i,
    input  logic [31:0] jr_target_i,
`ifdef PC_EXC_EN
    input  logic        exc_i,
`endif
    pc_seq_if.master    imem,
    output logic        redirect_pending_o
);

    state_e      state_reg, state_next;
    logic        active_reg;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] pc4;
    logic        req;
    logic        accept;
    logic        flush;
    src_e        redirect_src;
    logic [31:0] redirect_target;

    // Request is held low until the first edge after reset, and whenever IF is frozen.
    assign pc4    = pc_reg + 32'd4;
    assign req    = active_reg & ~stall_i;
    assign accept = req & imem.imem_ready_i;

`ifdef PC_EXC_EN
    assign flush = exc_i;
`else
    assign flush = 1'b0;
`endif

    redirect_buf u_redirect_buf (
        .clk               (clk),
        .reset             (reset),
        .br_taken_i        (br_taken_i),
        .br_target_i       (br_target_i),
        .jump_i            (jump_i),
        .jump_target_i     (jump_target_i),
        .jr_i              (jr_i),
        .jr_target_i       (jr_target_i),
        .accept_i          (accept),
        .flush_i           (flush),
        .redirect_src_o    (redirect_src),
        .redirect_target_o (redirect_target),
        .pending_o         (redirect_pending_o)
    );

    // Next state and next PC; state only moves on cycles where a request is issued.
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        case (state_reg)
            FETCH:   if (req && !imem.imem_ready_i) state_next = WAIT;
            WAIT:    if (accept)                    state_next = FETCH;
            default: state_next = FETCH;
        endcase
        if (accept) begin
            case (redirect_src)
                SRC_NONE: pc_next = pc4;
                default:  pc_next = redirect_target;
            endcase
        end
`ifdef PC_EXC_EN
        if (exc_i) begin
            pc_next    = align_pc(EXC_VECTOR);
            state_next = FETCH;
        end
`endif
    end

    // State, PC and request-enable registers with asynchronous reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= FETCH;
            active_reg <= 1'b0;
            pc_reg     <= RESET_PC;
        end else begin
            state_reg  <= state_next;
            active_reg <= 1'b1;
            pc_reg     <= pc_next;
        end
    end

    assign imem.imem_req_o = req;
    assign imem.pc_o       = pc_reg;
    assign imem.pc4_o      = pc4;

endmodule
